input_port_buffer: RTL and testbench
====================================

# input_port_buffer

Per-port input FIFO that sits upstream of a router's switch controller on each input link (S/E/W/L). It captures flits from the upstream link and presents the head packet's destination address and payload to the controller's route-compute and arbiters. It dequeues on the controller's grant and drives the buffer-full back-pressure that the upstream router's controller samples before granting.

## Interface
Parameters:
- DEPTH, 4, number of flit slots; power of two, ≥ 2.
- DATA_W, 32, payload width.

Ports:
- clk  input  1  router clock.
- rst  input  1  asynchronous, active-high reset.
- link_valid_i  input  1  upstream flit present this cycle.
- link_addr_i  input  8  destination address; [7:4] = X, [3:0] = Y.
- link_data_i  input  DATA_W  flit payload.
- buffer_full_o  output  1  back-pressure to upstream controller.
- packet_valid_o  output  1  head flit present.
- packet_addr_o  output  8  head flit destination address, to the controller's route compute.
- packet_data_o  output  DATA_W  head flit payload, to the crossbar.
- grant_pop_i  input  1  controller granted the head flit; it leaves the buffer at this edge.
- count_o  output  $clog2(DEPTH)+1  current occupancy.
- overflow_o  output  1  sticky: a flit was dropped.

## Operation
- Storage is a circular array with wr_ptr and rd_ptr, each $clog2(DEPTH) bits, both wrapping modulo DEPTH. count is held in a register.
- pop_eff = grant_pop_i && (count != 0). A grant_pop_i while empty is ignored, with no state change.
- push_eff = link_valid_i && (count < DEPTH || pop_eff). A push while full is accepted when a pop happens in the same cycle.
- push_drop = link_valid_i && !push_eff. The flit is discarded and overflow_o is set to 1.
- Count update:
  - count + 1 on push only.
  - count − 1 on pop only.
  - Unchanged on push plus pop, or on neither.
- Write: mem[wr_ptr] ← {addr, data}, and wr_ptr increments on push_eff.
- Read: rd_ptr increments on pop_eff.
- Head outputs come combinationally from the registered mem[rd_ptr] and count:
  - packet_valid_o = (count != 0).
  - packet_addr_o and packet_data_o are forced to 0 when count == 0.
- buffer_full_o is decoded from the count register only, with no path from grant_pop_i or link_valid_i. The threshold is set by the Configuration section.
- overflow_o is cleared only by rst.
- Reset, including mid-operation: all of the following clear immediately, and in-flight contents are discarded:
  - pointers and count → 0
  - packet_valid_o → 0
  - packet_addr_o and packet_data_o → 0
  - buffer_full_o → 0
  - overflow_o → 0
  - count_o → 0

## Timing
- Write-to-head latency is 1 cycle. A flit accepted at edge k into an empty buffer shows packet_valid_o = 1 and its addr/data from edge k through to the next edge. There is no same-cycle bypass.
- Pop: the head advances at the grant edge. The next flit, or empty, is visible after that edge.
- Simultaneous push and pop when count == 1: count stays 1, and the new flit becomes head after the edge.
- buffer_full_o changes only on clock edges, or asynchronously on rst.
- Wrap-around: pointers roll from DEPTH−1 to 0 with no bubble. Order is strict FIFO.

## Configuration
- IPB_EARLY_FULL_EN defined:
  - buffer_full_o = (count >= DEPTH−1).
  - This reserves one slot for a flit already in flight on a one-cycle link, because the upstream controller sees full one cycle late.
- IPB_EARLY_FULL_EN undefined:
  - buffer_full_o = (count == DEPTH).
- The push/drop rules are identical in both builds.

## Test plan
- Reset/idle: assert rst mid-stream with 3 flits held → all outputs 0 at once. After release, grant_pop_i = 1 for 5 cycles → count_o stays 0 and overflow_o stays 0.
- Ordering and wrap (DEPTH = 4): push addr 0x11, 0x22, 0x33, pop one, then push 0x44 and 0x55 → heads pop out as 0x22, 0x33, 0x44, 0x55 in order across the pointer wrap. packet_valid_o = 0 afterwards.
- Full threshold: push 4 flits with no pops:
  - Without the macro: buffer_full_o rises after the 4th edge.
  - With IPB_EARLY_FULL_EN: it rises after the 3rd edge.
  - In both builds count_o = 4.
- Overflow: with count = 4, push 0x66 without a pop → 0x66 dropped, overflow_o = 1 and stays 1, count_o = 4.
- Full with simultaneous push/pop: count = 4, push 0x77 and pop in the same cycle → count_o stays 4, no overflow, and 0x77 is the last flit to drain.
- Empty with simultaneous push/pop: count = 0, link_valid_i = 1 with addr 0x3A and grant_pop_i = 1 → the pop is ignored, and the next cycle shows count_o = 1 and packet_addr_o = 0x3A.

Source files
------------

// File: rtl/input_port_buffer_if.sv
// Link-side and controller-side signals of one router input port buffer.
// master = upstream link plus switch controller, slave = the buffer itself.
interface input_port_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              link_valid_i;
  logic [7:0]        link_addr_i;
  logic [DATA_W-1:0] link_data_i;
  logic              grant_pop_i;
  logic              buffer_full_o;
  logic              packet_valid_o;
  logic [7:0]        packet_addr_o;
  logic [DATA_W-1:0] packet_data_o;
  logic [CNT_W-1:0]  count_o;
  logic              overflow_o;

  modport master (
    output link_valid_i, link_addr_i, link_data_i, grant_pop_i,
    input  buffer_full_o, packet_valid_o, packet_addr_o, packet_data_o, count_o, overflow_o
  );

  modport slave (
    input  link_valid_i, link_addr_i, link_data_i, grant_pop_i,
    output buffer_full_o, packet_valid_o, packet_addr_o, packet_data_o, count_o, overflow_o
  );
endinterface

// File: rtl/input_port_buffer.sv
// Per-port input FIFO presenting the head flit to the switch controller.
// Define IPB_EARLY_FULL_EN to raise buffer_full_o one slot early (count >= DEPTH-1).
module input_port_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input logic                clk,
  input logic                rst,
  input_port_buffer_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = 8 + DATA_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_full;
  logic [ENT_W-1:0] w_head;

  // A full buffer still accepts a flit when the head leaves in the same cycle.
  always_comb begin
    w_empty = (r_count == CNT_W'(0));
    w_pop   = bus.grant_pop_i && !w_empty;
    w_push  = bus.link_valid_i && ((r_count < FULL_CNT) || w_pop);
    w_drop  = bus.link_valid_i && !w_push;
  end

  // Full is decoded from the count register only, so it moves on clock edges.
`ifdef IPB_EARLY_FULL_EN
  assign w_full = (r_count >= (FULL_CNT - CNT_W'(1)));
`else
  assign w_full = (r_count == FULL_CNT);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Storage needs no reset: an empty count masks stale contents at the head.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.link_addr_i, bus.link_data_i};
  end

  always_comb begin
    w_head             = w_empty ? '0 : r_mem[r_rd_ptr];
    bus.packet_valid_o = !w_empty;
    bus.packet_addr_o  = w_head[ENT_W-1 -: 8];
    bus.packet_data_o  = w_head[DATA_W-1:0];
    bus.buffer_full_o  = w_full;
    bus.count_o        = r_count;
    bus.overflow_o     = r_overflow;
  end
endmodule

// File: tb/tb_input_port_buffer.sv
// Directed bench for input_port_buffer: expected flits are queued at issue time and
// a negedge monitor checks each head flit as the controller grants it.
module tb_input_port_buffer;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_tot  = 0;
  int   m_cnt  = 0;
  logic [39:0] exp_q [$];
`ifdef IPB_EARLY_FULL_EN
  logic [3:0] exp_full = 4'b1100;
`else
  logic [3:0] exp_full = 4'b1000;
`endif

  input_port_buffer_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

  input_port_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: a granted head flit must match the oldest expected flit.
  always @(negedge clk) begin
    if (!rst && bus.grant_pop_i && bus.packet_valid_o) begin
      if (exp_q.size() == 0) begin
        n_tot++;
        $display("FAIL head_unexpected: got addr 0x%0h with no flit expected", bus.packet_addr_o);
      end else begin
        chk("head_flit", 64'({bus.packet_addr_o, bus.packet_data_o}), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic set_in(input logic v, input logic [7:0] a, input logic p);
    bus.link_valid_i = v;
    bus.link_addr_i  = a;
    bus.link_data_i  = {24'hC0FFEE, a};
    bus.grant_pop_i  = p;
  endtask

  // One clock: drive, queue the expected flit if it should be accepted, check count after the edge.
  task automatic step(input logic v, input logic [7:0] a, input logic p);
    logic pop_m;
    logic push_m;
    set_in(v, a, p);
    pop_m  = p && (m_cnt != 0);
    push_m = v && ((m_cnt < DEPTH) || pop_m);
    if (push_m) exp_q.push_back({a, 24'hC0FFEE, a});
    m_cnt = m_cnt + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
    @(posedge clk);
    #1;
    chk("count", 64'(bus.count_o), 64'(m_cnt));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 64'(bus.packet_valid_o), 64'h0);
    chk({tag, "_addr"},  64'(bus.packet_addr_o),  64'h0);
    chk({tag, "_data"},  64'(bus.packet_data_o),  64'h0);
    chk({tag, "_full"},  64'(bus.buffer_full_o),  64'h0);
    chk({tag, "_ovf"},   64'(bus.overflow_o),     64'h0);
    chk({tag, "_count"}, 64'(bus.count_o),        64'h0);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    set_in(1'b0, 8'h00, 1'b0);
    #1;
    rst = 1'b1;
    exp_q.delete();
    m_cnt = 0;
    #1;
    check_zero("rst_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    set_in(1'b0, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Three flits held, then reset mid-stream.
    step(1'b1, 8'hA1, 1'b0);
    step(1'b1, 8'hA2, 1'b0);
    step(1'b1, 8'hA3, 1'b0);
    chk("held_valid", 64'(bus.packet_valid_o), 64'h1);
    do_reset();

    // Grants on an empty buffer change nothing.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("idle_ovf", 64'(bus.overflow_o), 64'h0);
    end

    // Ordering across the pointer wrap.
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h44, 1'b0);
    step(1'b1, 8'h55, 1'b0);
    chk("wrap_head", 64'(bus.packet_addr_o), 64'h22);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    chk("drained_valid", 64'(bus.packet_valid_o), 64'h0);
    chk("drained_addr",  64'(bus.packet_addr_o),  64'h0);
    chk("drained_data",  64'(bus.packet_data_o),  64'h0);

    // Full threshold.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'(8'hB1 + 8'(i)), 1'b0);
      chk("full_thresh", 64'(bus.buffer_full_o), 64'(exp_full[i]));
    end

    // Overflow drop, sticky.
    step(1'b1, 8'h66, 1'b0);
    chk("ovf_set",   64'(bus.overflow_o),    64'h1);
    chk("ovf_full",  64'(bus.buffer_full_o), 64'h1);
    chk("ovf_head",  64'(bus.packet_addr_o), 64'hB1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("ovf_sticky", 64'(bus.overflow_o), 64'h1);
    do_reset();

    // Full with simultaneous push and pop.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC1 + 8'(i)), 1'b0);
    step(1'b1, 8'h77, 1'b1);
    chk("pp_full_ovf",  64'(bus.overflow_o),    64'h0);
    chk("pp_full_head", 64'(bus.packet_addr_o), 64'hC2);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    chk("pp_drained", 64'(bus.packet_valid_o), 64'h0);

    // Empty with simultaneous push and pop: pop ignored.
    step(1'b1, 8'h3A, 1'b1);
    chk("pp_empty_valid", 64'(bus.packet_valid_o), 64'h1);
    chk("pp_empty_addr",  64'(bus.packet_addr_o),  64'h3A);
    chk("pp_empty_data",  64'(bus.packet_data_o),  64'hC0FFEE3A);
    step(1'b0, 8'h00, 1'b1);

    set_in(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
